// File: rtl/mips_pkg.sv
// Shared opcode constants and width helpers for the MIPS pipeline blocks.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // A single register still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Architectural register file: two combinational read ports, one write port,
// register 0 hard-wired to zero, write-first bypass from the write port.
module reg_file_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  localparam int RA_W   = idx_width(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RA_W-1:0]   ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage: register read, early branch resolution with MEM forwarding,
// hazard stall generation and the ID/EX pipeline register.
module id_stage_hazard
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_CNT = 32,
  parameter bit BNE_EN  = 1'b1,
  localparam int RA_W   = idx_width(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] pcPlus4,
  input  logic              RegWrite,
  input  logic [RA_W-1:0]   write_reg,
  input  logic [DATA_W-1:0] write_data_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_dst,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [RA_W-1:0]   mem_dst,
  input  logic [DATA_W-1:0] mem_alu_result,
  output logic              stall,
  output logic              if_flush,
  output logic [ADDR_W-1:0] branch_target,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [RA_W-1:0]   idex_rs,
  output logic [RA_W-1:0]   idex_rt,
  output logic [RA_W-1:0]   idex_rd,
  output logic [5:0]        idex_opcode,
  output logic [5:0]        idex_func,
  output logic [ADDR_W-1:0] idex_pcPlus4
);

  logic [5:0]        opcode, func;
  logic [4:0]        rs_f, rt_f, rd_f;
  logic [RA_W-1:0]   rs, rt, rd;
  logic signed [15:0] imm16;
  logic [DATA_W-1:0] imm, rs_val, rt_val, cmp_a, cmp_b;
  logic is_beq, is_bne, is_branch, use_rt;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic load_use, br_ex, br_mem, hazard, taken;

  function automatic logic hit(input logic [RA_W-1:0] dst, input logic [RA_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  assign opcode = instruction[31:26];
  assign rs_f   = instruction[25:21];
  assign rt_f   = instruction[20:16];
  assign rd_f   = instruction[15:11];
  assign func   = instruction[5:0];
  assign imm16  = instruction[15:0];
  assign rs     = rs_f[RA_W-1:0];
  assign rt     = rt_f[RA_W-1:0];
  assign rd     = rd_f[RA_W-1:0];
  assign imm    = DATA_W'(imm16);

  reg_file_bypass #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWrite),
    .wa  (write_reg),
    .wd  (write_data_reg),
    .ra1 (rs),
    .rd1 (rs_val),
    .ra2 (rt),
    .rd2 (rt_val)
  );

  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = BNE_EN && (opcode == OP_BNE);
  assign is_branch = if_valid && (is_beq || is_bne);
  assign use_rt    = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_beq || is_bne;

  assign ex_rs  = hit(ex_dst, rs);
  assign ex_rt  = hit(ex_dst, rt);
  assign mem_rs = hit(mem_dst, rs);
  assign mem_rt = hit(mem_dst, rt);

  // A branch compares in ID, so it must also wait for an EX result or a MEM load.
  assign load_use = ex_mem_read && (ex_rs || (use_rt && ex_rt));
  assign br_ex    = is_branch && ex_reg_write && (ex_rs || ex_rt);
  assign br_mem   = is_branch && mem_mem_read && (mem_rs || mem_rt);
  assign hazard   = load_use || br_ex || br_mem;

  assign cmp_a = (mem_reg_write && !mem_mem_read && mem_rs) ? mem_alu_result : rs_val;
  assign cmp_b = (mem_reg_write && !mem_mem_read && mem_rt) ? mem_alu_result : rt_val;

  assign stall         = !rst && if_valid && hazard;
  assign taken         = is_branch && !stall && (is_beq ? (cmp_a == cmp_b) : (cmp_a != cmp_b));
  assign if_flush      = !rst && taken;
  assign branch_target = pcPlus4 + (ADDR_W'(imm16) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid   <= 1'b0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
      idex_opcode  <= '0;
      idex_func    <= '0;
      idex_pcPlus4 <= '0;
    end else if (stall || !if_valid) begin
      idex_valid <= 1'b0;
    end else begin
      idex_valid   <= 1'b1;
      idex_rs_data <= rs_val;
      idex_rt_data <= rt_val;
      idex_imm     <= imm;
      idex_rs      <= rs;
      idex_rt      <= rt;
      idex_rd      <= rd;
      idex_opcode  <= opcode;
      idex_func    <= func;
      idex_pcPlus4 <= pcPlus4;
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed plus randomized bench for id_stage_hazard, with BNE enabled and disabled.
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  logic        rst, if_valid, RegWrite, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
  logic [31:0] instruction, pcPlus4, write_data_reg, mem_alu_result;
  logic [4:0]  write_reg, ex_dst, mem_dst;

  logic        stall0, if_flush0, idex_valid0;
  logic [31:0] branch_target0, idex_rs_data0, idex_rt_data0, idex_imm0, idex_pcPlus40;
  logic [4:0]  idex_rs0, idex_rt0, idex_rd0;
  logic [5:0]  idex_opcode0, idex_func0;

  logic        stall1, if_flush1, idex_valid1;
  logic [31:0] branch_target1, idex_rs_data1, idex_rt_data1, idex_imm1, idex_pcPlus41;
  logic [4:0]  idex_rs1, idex_rt1, idex_rd1;
  logic [5:0]  idex_opcode1, idex_func1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic        cur_s0, cur_s1;
  logic        e_valid0, e_valid1;
  logic [31:0] e_rs_data, e_rt_data, e_imm, e_pc;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [5:0]  e_op, e_func;

  always #5 clk = ~clk;

  id_stage_hazard #(.DATA_W(32), .ADDR_W(32), .REG_CNT(32), .BNE_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pcPlus4(pcPlus4),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data_reg(write_data_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .mem_alu_result(mem_alu_result),
    .stall(stall0), .if_flush(if_flush0), .branch_target(branch_target0), .idex_valid(idex_valid0),
    .idex_rs_data(idex_rs_data0), .idex_rt_data(idex_rt_data0), .idex_imm(idex_imm0),
    .idex_rs(idex_rs0), .idex_rt(idex_rt0), .idex_rd(idex_rd0),
    .idex_opcode(idex_opcode0), .idex_func(idex_func0), .idex_pcPlus4(idex_pcPlus40)
  );

  id_stage_hazard #(.DATA_W(32), .ADDR_W(32), .REG_CNT(32), .BNE_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction), .pcPlus4(pcPlus4),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data_reg(write_data_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .mem_alu_result(mem_alu_result),
    .stall(stall1), .if_flush(if_flush1), .branch_target(branch_target1), .idex_valid(idex_valid1),
    .idex_rs_data(idex_rs_data1), .idex_rt_data(idex_rt_data1), .idex_imm(idex_imm1),
    .idex_rs(idex_rs1), .idex_rt(idex_rt1), .idex_rd(idex_rd1),
    .idex_opcode(idex_opcode1), .idex_func(idex_func1), .idex_pcPlus4(idex_pcPlus41)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] im);
    return {6'(op), 5'(rs), 5'(rt), im};
  endfunction

  // Architectural read as seen in decode: r0 is zero, a same-cycle WB write wins.
  function automatic logic [31:0] m_rd(input int idx);
    if (idx == 0) return 32'h0;
    if (RegWrite && int'(write_reg) == idx) return write_data_reg;
    return mregs[idx];
  endfunction

  task automatic model_comb(input bit bne_en, output logic e_stall, output logic e_flush,
                            output logic e_br, output logic [31:0] e_tgt);
    int op, rs, rt, simm, exd, memd;
    logic use_rt, ex_rs, ex_rt, mem_rs, mem_rt, hz;
    logic [31:0] a, b;
    op   = int'(instruction[31:26]);
    rs   = int'(instruction[25:21]);
    rt   = int'(instruction[20:16]);
    exd  = int'(ex_dst);
    memd = int'(mem_dst);
    e_br   = if_valid && (op == 4 || (bne_en && op == 5));
    use_rt = (op == 0) || (op == 43) || (op == 4) || (bne_en && op == 5);
    ex_rs  = (exd != 0) && (exd == rs);
    ex_rt  = (exd != 0) && (exd == rt);
    mem_rs = (memd != 0) && (memd == rs);
    mem_rt = (memd != 0) && (memd == rt);
    hz = (ex_mem_read && (ex_rs || (use_rt && ex_rt)))
      || (e_br && ex_reg_write && (ex_rs || ex_rt))
      || (e_br && mem_mem_read && (mem_rs || mem_rt));
    e_stall = !rst && if_valid && hz;
    a = (mem_reg_write && !mem_mem_read && mem_rs) ? mem_alu_result : m_rd(rs);
    b = (mem_reg_write && !mem_mem_read && mem_rt) ? mem_alu_result : m_rd(rt);
    e_flush = !rst && e_br && !e_stall && ((op == 4) ? (a == b) : (a != b));
    simm  = int'($signed(instruction[15:0]));
    e_tgt = pcPlus4 + 32'(simm * 4);
  endtask

  task automatic settle();
    logic s0, f0, b0, s1, f1, b1;
    logic [31:0] t0, t1;
    #3;
    model_comb(1'b1, s0, f0, b0, t0);
    model_comb(1'b0, s1, f1, b1, t1);
    chk("stall_bne1", stall0, s0);
    chk("flush_bne1", if_flush0, f0);
    chk("stall_bne0", stall1, s1);
    chk("flush_bne0", if_flush1, f1);
    if (b0) chk("target_bne1", branch_target0, t0);
    if (b1) chk("target_bne0", branch_target1, t1);
    cur_s0 = s0;
    cur_s1 = s1;
  endtask

  task automatic commit();
    if (rst) begin
      e_valid0 = 0; e_valid1 = 0;
      e_rs_data = 0; e_rt_data = 0; e_imm = 0; e_pc = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_op = 0; e_func = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else begin
      e_valid0 = if_valid && !cur_s0;
      e_valid1 = if_valid && !cur_s1;
      if (e_valid0) begin
        e_rs      = instruction[25:21];
        e_rt      = instruction[20:16];
        e_rd      = instruction[15:11];
        e_rs_data = m_rd(int'(e_rs));
        e_rt_data = m_rd(int'(e_rt));
        e_imm     = 32'(int'($signed(instruction[15:0])));
        e_op      = instruction[31:26];
        e_func    = instruction[5:0];
        e_pc      = pcPlus4;
      end
      if (RegWrite && write_reg != 0) mregs[write_reg] = write_data_reg;
    end
    @(posedge clk);
    #1;
    chk("idex_valid_bne1", idex_valid0, e_valid0);
    chk("idex_valid_bne0", idex_valid1, e_valid1);
    chk("idex_rs_data", idex_rs_data0, e_rs_data);
    chk("idex_rt_data", idex_rt_data0, e_rt_data);
    chk("idex_imm", idex_imm0, e_imm);
    chk("idex_idx", {idex_rs0, idex_rt0, idex_rd0}, {e_rs, e_rt, e_rd});
    chk("idex_op_func", {idex_opcode0, idex_func0}, {e_op, e_func});
    chk("idex_pc", idex_pcPlus40, e_pc);
  endtask

  task automatic step();
    settle();
    commit();
  endtask

  task automatic idle();
    rst = 0; if_valid = 0; instruction = 0; pcPlus4 = 0;
    RegWrite = 0; write_reg = 0; write_data_reg = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_dst = 0; mem_alu_result = 0;
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h5;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    cur_s0 = 0; cur_s1 = 0;

    // Reset forces stall low even with a load-use hazard present.
    idle(); rst = 1; if_valid = 1; ex_mem_read = 1; ex_dst = 8; instruction = rtype(8, 10, 9, 32);
    settle(); chk("rst_stall", stall0, 1'b0);
    commit(); chk("rst_valid", idex_valid0, 1'b0);

    idle(); RegWrite = 1; write_reg = 5; write_data_reg = 32'h1234; step();
    idle(); if_valid = 1; instruction = rtype(5, 0, 1, 32); step();
    chk("r5_written", idex_rs_data0, 32'h1234);
    idle(); rst = 1; step();
    idle(); if_valid = 1; instruction = rtype(5, 0, 1, 32); step();
    chk("r5_after_rst", idex_rs_data0, 32'h0);

    // Load-use on rs
    idle(); if_valid = 1; ex_mem_read = 1; ex_dst = 8; instruction = rtype(8, 10, 9, 32);
    settle(); chk("lu_stall", stall0, 1'b1);
    commit(); chk("lu_bubble", idex_valid0, 1'b0);
    ex_mem_read = 0;
    settle(); chk("lu_release", stall0, 1'b0);
    commit(); chk("lu_valid", idex_valid0, 1'b1);

    // BEQ with MEM forwarding into the comparator
    idle(); RegWrite = 1; write_reg = 3; write_data_reg = 5; step();
    write_reg = 4; write_data_reg = 7; step();
    idle(); if_valid = 1; mem_reg_write = 1; mem_dst = 4; mem_alu_result = 5;
    instruction = itype(4, 3, 4, 16'd4); pcPlus4 = 32'h100;
    settle(); chk("beq_fwd_flush", if_flush0, 1'b1); chk("beq_target", branch_target0, 32'h110);
    commit();

    // BNE with WB bypass, and BNE disabled
    idle(); RegWrite = 1; write_reg = 6; write_data_reg = 9; step();
    write_reg = 2; write_data_reg = 1; step();
    idle(); RegWrite = 1; write_reg = 2; write_data_reg = 9; if_valid = 1;
    instruction = itype(5, 2, 6, 16'hFFFF); pcPlus4 = 32'h200;
    settle(); chk("bne_bypass_flush", if_flush0, 1'b0); chk("bne_neg_target", branch_target0, 32'h1FC);
    commit();
    idle(); if_valid = 1; instruction = itype(5, 3, 4, 16'd1);
    settle(); chk("bne_taken", if_flush0, 1'b1); chk("bne_off_taken", if_flush1, 1'b0);
    commit();
    idle(); if_valid = 1; ex_reg_write = 1; ex_dst = 3; instruction = itype(5, 3, 4, 16'd1);
    settle(); chk("bne_ex_stall", stall0, 1'b1); chk("bne_off_nostall", stall1, 1'b0);
    commit();

    // Branch on an EX result: stall, then resolve through MEM forwarding
    idle(); if_valid = 1; ex_reg_write = 1; ex_dst = 3; instruction = itype(4, 3, 0, 16'd8);
    settle(); chk("brex_stall", stall0, 1'b1); chk("brex_noflush", if_flush0, 1'b0);
    commit(); chk("brex_bubble", idex_valid0, 1'b0);
    ex_reg_write = 0; mem_reg_write = 1; mem_dst = 3; mem_alu_result = 0;
    settle(); chk("brex_resolve_stall", stall0, 1'b0); chk("brex_resolve_flush", if_flush0, 1'b1);
    commit(); chk("brex_valid", idex_valid0, 1'b1);

    // Register 0 writes are ignored, dst 0 never stalls
    idle(); RegWrite = 1; write_reg = 0; write_data_reg = 32'hFFFF; if_valid = 1;
    ex_mem_read = 1; ex_dst = 0; instruction = rtype(0, 0, 1, 32);
    settle(); chk("r0_nostall", stall0, 1'b0);
    commit(); chk("r0_bypass", idex_rs_data0, 32'h0);
    idle(); if_valid = 1; instruction = rtype(0, 0, 1, 32); step();
    chk("r0_read", idex_rs_data0, 32'h0);

    // Reset during a stall drops it
    idle(); if_valid = 1; ex_mem_read = 1; ex_dst = 8; instruction = rtype(8, 10, 9, 32);
    settle(); chk("midrst_pre", stall0, 1'b1);
    commit();
    rst = 1;
    settle(); chk("midrst_stall", stall0, 1'b0);
    commit(); chk("midrst_valid", idex_valid0, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      int op;
      case ($urandom_range(0, 5))
        0: op = 0; 1: op = 4; 2: op = 5; 3: op = 35; 4: op = 43; default: op = 8;
      endcase
      rst            = ($urandom_range(0, 39) == 0);
      if_valid       = ($urandom_range(0, 7) != 0);
      instruction    = {6'(op), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom), 6'($urandom)};
      pcPlus4        = $urandom;
      RegWrite       = $urandom_range(0, 1);
      write_reg      = 5'($urandom_range(0, 7));
      write_data_reg = pick_data();
      ex_reg_write   = $urandom_range(0, 1);
      ex_mem_read    = ($urandom_range(0, 3) == 0);
      ex_dst         = 5'($urandom_range(0, 7));
      mem_reg_write  = $urandom_range(0, 1);
      mem_mem_read   = ($urandom_range(0, 3) == 0);
      mem_dst        = 5'($urandom_range(0, 7));
      mem_alu_result = pick_data();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
